bcd_serial_add_ctrl: RTL and testbench

BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_fadd.sv | 26 ++
 rtl/bcd_serial_add_ctrl.sv | 135 +++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder: controller state encoding,
// the largest legal BCD digit value, and a digit validity helper.
package bcd_pkg;

   localparam logic [3:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic digit_invalid(input logic [3:0] digit);
      return digit > BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_fadd.sv
// Single-digit BCD full adder: binary add plus decimal correction of +6
// (mod 16) whenever the binary sum exceeds 9.
module bcd_fadd
   import bcd_pkg::*;
(
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       c_i,
   output logic [3:0] s_o,
   output logic       c_o
);

   logic [4:0] bin_sum;

   // Binary digit sum followed by decimal correction
   always_comb begin
      bin_sum = {1'b0, a_i} + {1'b0, b_i} + {4'b0, c_i};
      s_o     = bin_sum[3:0];
      c_o     = 1'b0;
      if (bin_sum > {1'b0, BCD_MAX}) begin
         s_o = bin_sum[3:0] + 4'd6;
         c_o = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Serial BCD adder controller: latches two packed BCD operands, then adds
// them one digit per cycle, LSB first, through a single reused bcd_fadd.
//
//   state | meaning
//   IDLE  | waiting for start, ready=1
//   ADD   | one digit processed per edge, start ignored
//   DONE  | result complete for one cycle, start accepted back-to-back
module bcd_serial_add_ctrl
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  ready,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   sum,
   output logic                  cout,
   output logic                  err
);

   // 3 bits covers digit indices 0..7 for the full 1..8 digit range
   localparam int         CW   = 3;
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  carry_q, carry_d;
   logic [4*DIGITS-1:0]   a_q, a_d;
   logic [4*DIGITS-1:0]   b_q, b_d;
   logic [4*DIGITS-1:0]   sum_q, sum_d;
   logic                  cout_q, cout_d;
   logic                  err_q, err_d;

   logic                  any_invalid;
   logic [3:0]            fadd_s;
   logic                  fadd_c;

   bcd_fadd u_fadd (
      .a_i (a_q[int'(cnt_q)*4 +: 4]),
      .b_i (b_q[int'(cnt_q)*4 +: 4]),
      .c_i (carry_q),
      .s_o (fadd_s),
      .c_o (fadd_c)
   );

   // Flag any non-BCD digit on the live operands, sampled only at acceptance
   always_comb begin
      any_invalid = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (digit_invalid(a[i*4 +: 4]) || digit_invalid(b[i*4 +: 4])) begin
            any_invalid = 1'b1;
         end
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      err_d   = err_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               sum_d   = '0;
               cnt_d   = '0;
               cout_d  = 1'b0;
               err_d   = any_invalid;
               state_d = ADD;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         ADD: begin
            sum_d[int'(cnt_q)*4 +: 4] = fadd_s;
            carry_d = fadd_c;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               cout_d  = fadd_c;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared immediately by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
      end
   end

   // Status outputs decode straight from state so reset takes effect at once
   always_comb begin
      ready = (state_q != ADD);
      busy  = (state_q == ADD);
      done  = (state_q == DONE);
      sum   = sum_q;
      cout  = cout_q;
      err   = err_q;
   end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for the serial BCD adder controller (default 4 digits).
module tb_bcd_serial_add_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic        cout;
   logic        err;

   int n_chk  = 0;
   int n_fail = 0;

   bcd_serial_add_ctrl #(.DIGITS(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .ready (ready),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called just after a falling edge: launches an addition, optionally pokes
   // start and scrambles operands mid-flight, then returns at the falling
   // edge where done is seen and checks the result.
   task automatic run_add(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tcin, input int poke, input logic [15:0] esum,
                          input logic ecout, input logic eerr, input logic chk_sum);
      int lat;
      start = 1'b1;
      a     = ta;
      b     = tb;
      cin   = tcin;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy"},    32'(busy),  32'd1);
      chk({tag, "_rdy_add"}, 32'(ready), 32'd0);
      chk({tag, "_sum_clr"}, 32'(sum),   32'd0);
      lat = 0;
      while (!done && lat < 12) begin
         @(negedge clk);
         lat++;
         if (lat == poke) begin
            start = 1'b1;
            a     = 16'h4444;
            b     = 16'h4444;
            cin   = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk({tag, "_latency"}, 32'(lat),   32'd4);
      chk({tag, "_rdy_done"},32'(ready), 32'd1);
      chk({tag, "_busy_off"},32'(busy),  32'd0);
      if (chk_sum) begin
         chk({tag, "_sum"},  32'(sum),   32'(esum));
         chk({tag, "_cout"}, 32'(cout),  32'(ecout));
      end
      chk({tag, "_err"},     32'(err),   32'(eerr));
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_done",  32'(done),  32'd0);
      chk("rst_sum",   32'(sum),   32'd0);
      chk("rst_cout",  32'(cout),  32'd0);
      chk("rst_err",   32'(err),   32'd0);

      // start on the first edge after reset release
      rst = 1'b0;
      run_add("t1234", 16'h1234, 16'h5678, 1'b0, -1, 16'h6912, 1'b0, 1'b0, 1'b1);

      @(negedge clk);
      run_add("t9999", 16'h9999, 16'h0001, 1'b0, -1, 16'h0000, 1'b1, 1'b0, 1'b1);

      @(negedge clk);
      run_add("tcin", 16'h0000, 16'h0000, 1'b1, -1, 16'h0001, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("tcin_done_1cyc", 32'(done),  32'd0);
      chk("tcin_sum_held",  32'(sum),   32'h0001);
      chk("tcin_idle_rdy",  32'(ready), 32'd1);

      run_add("tcarry", 16'h0999, 16'h0001, 1'b1, -1, 16'h1001, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      run_add("ttop", 16'h5000, 16'h5000, 1'b0, -1, 16'h0000, 1'b1, 1'b0, 1'b1);

      // start pulsed and operands changed mid-ADD must have no effect
      @(negedge clk);
      run_add("tignore", 16'h1111, 16'h2222, 1'b0, 2, 16'h3333, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("tignore_idle", 32'(ready), 32'd1);
      chk("tignore_held", 32'(sum),   32'h3333);

      // reset after two digits have been written
      start = 1'b1;
      a     = 16'h5555;
      b     = 16'h4444;
      cin   = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("trst_partial", 32'(sum), 32'h0099);
      rst = 1'b1;
      #1;
      chk("trst_sum",   32'(sum),   32'd0);
      chk("trst_ready", 32'(ready), 32'd1);
      chk("trst_busy",  32'(busy),  32'd0);
      chk("trst_done",  32'(done),  32'd0);
      chk("trst_cout",  32'(cout),  32'd0);
      chk("trst_err",   32'(err),   32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_add("tpost", 16'h1234, 16'h5678, 1'b0, -1, 16'h6912, 1'b0, 1'b0, 1'b1);

      // invalid digit flags err; start accepted straight out of DONE
      @(negedge clk);
      run_add("terr", 16'h00A0, 16'h0000, 1'b0, -1, 16'h0000, 1'b0, 1'b1, 1'b0);
      run_add("tb2b", 16'h0005, 16'h0004, 1'b0, -1, 16'h0009, 1'b0, 1'b0, 1'b1);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
